// File: rtl/stage4_memory_access_pkg.sv
// stage4_memory_access_pkg: shared RISC-V types and constants for the memory stage
package stage4_memory_access_pkg;
    localparam int REGISTER_WIDTH = 32;
    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [2:0] FUNCT3_LB = 3'd0;
    localparam logic [2:0] FUNCT3_LH = 3'd1;
    localparam logic [2:0] FUNCT3_LW = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB = 3'd0;
    localparam logic [2:0] FUNCT3_SH = 3'd1;
    localparam logic [2:0] FUNCT3_SW = 3'd2;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        logic [REGISTER_WIDTH-1:0] alu_result;
        logic [REGISTER_WIDTH-1:0] store_data;
        logic [REGISTER_WIDTH-1:0] branch_target;
    } memory_stage_payload_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        logic [REGISTER_WIDTH-1:0] alu_result;
        logic [REGISTER_WIDTH-1:0] data_from_memory;
        logic [REGISTER_WIDTH-1:0] branch_target;
    } writeback_payload_t;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESPONSE, OUTPUT} mem_stage_state_t;

    // funct3[1:0] encodes the access size for both loads and stores: 0 byte, 1 half, 2 word
    function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] offset);
        return size[1] ? |offset : size[0] & offset[0];
    endfunction
endpackage

// File: rtl/stage4_memory_access_if.sv
// stage4_memory_access_if: valid/ready stream carrying a packed payload
interface stage4_memory_access_if #(parameter int W = 1);
    logic tvalid;
    logic tready;
    logic [W-1:0] tdata;
    modport master (output tvalid, output tdata, input tready);
    modport slave (input tvalid, input tdata, output tready);
endinterface

// File: rtl/stage4_memory_access_store_lane.sv
// store_lane_formatter: places store data on byte lanes and flags misaligned accesses
module store_lane_formatter
    import stage4_memory_access_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    input  logic [REGISTER_WIDTH-1:0] rs2,
    output logic [REGISTER_WIDTH/8-1:0] byte_enable,
    output logic [REGISTER_WIDTH-1:0] wdata,
    output logic misaligned
);
    // lane replication, byte enables and natural-alignment check (same rule for loads)
    always_comb begin
        byte_enable = size[1] ? 4'b1111 : ((size[0] ? 4'b0011 : 4'b0001) << offset);
        wdata = size[1] ? rs2 : size[0] ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
        misaligned = misaligned_access(size, offset);
    end
endmodule

// File: rtl/stage4_memory_access.sv
// stage4_memory_access: pipeline stage performing data-memory loads and stores
module stage4_memory_access
    import stage4_memory_access_pkg::*;
#(
    parameter int DMEM_ADDRESS_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    stage4_memory_access_if.slave axis_execute_to_memory,
    stage4_memory_access_if.master axis_memory_to_writeback,
    output logic dmem_req_valid,
    input  logic dmem_req_ready,
    output logic dmem_req_write,
    output logic [DMEM_ADDRESS_WIDTH-1:0] dmem_req_address,
    output logic [REGISTER_WIDTH-1:0] dmem_req_wdata,
    output logic [REGISTER_WIDTH/8-1:0] dmem_req_byte_enable,
    input  logic dmem_resp_valid,
    input  logic [REGISTER_WIDTH-1:0] dmem_resp_rdata,
    output logic misaligned_error
);
    mem_stage_state_t state, state_n;
    memory_stage_payload_t in_p;
    writeback_payload_t out_q;
    logic in_ready, capture, is_load, is_store, misaligned, go_mem;
    logic [REGISTER_WIDTH/8-1:0] lane_be;
    logic [REGISTER_WIDTH-1:0] lane_wdata;

    assign in_p = axis_execute_to_memory.tdata;
    assign axis_execute_to_memory.tready = in_ready;
    assign axis_memory_to_writeback.tvalid = state == OUTPUT;
    assign axis_memory_to_writeback.tdata = out_q;

    store_lane_formatter u_lane (
        .size(in_p.decoded_instruction.funct3[1:0]),
        .offset(in_p.alu_result[1:0]),
        .rs2(in_p.store_data),
        .byte_enable(lane_be),
        .wdata(lane_wdata),
        .misaligned(misaligned)
    );

    // input acceptance, instruction classification and next-state selection
    always_comb begin
        in_ready = state == IDLE || (state == OUTPUT && axis_memory_to_writeback.tready);
        capture = in_ready && axis_execute_to_memory.tvalid;
        is_load = in_p.decoded_instruction.opcode == OPCODE_LOAD;
        is_store = in_p.decoded_instruction.opcode == OPCODE_STORE;
        go_mem = (is_load || is_store) && !misaligned;
        state_n = capture ? (go_mem ? REQUEST : OUTPUT)
                : state == REQUEST ? (dmem_req_ready ? (dmem_req_write ? OUTPUT : WAIT_RESPONSE) : REQUEST)
                : state == WAIT_RESPONSE ? (dmem_resp_valid ? OUTPUT : WAIT_RESPONSE)
                : (state == OUTPUT && !axis_memory_to_writeback.tready) ? OUTPUT : IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // output payload and memory request registers; request fields stay frozen until acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            misaligned_error <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_write <= 1'b0;
            dmem_req_address <= '0;
            dmem_req_wdata <= '0;
            dmem_req_byte_enable <= '0;
        end else begin
            misaligned_error <= capture && (is_load || is_store) && misaligned;
            if (capture) begin
                out_q <= '{decoded_instruction: in_p.decoded_instruction, alu_result: in_p.alu_result,
                           data_from_memory: '0, branch_target: in_p.branch_target};
                dmem_req_valid <= go_mem;
                dmem_req_write <= is_store;
                dmem_req_address <= DMEM_ADDRESS_WIDTH'({in_p.alu_result[REGISTER_WIDTH-1:2], 2'b00});
                dmem_req_wdata <= is_store ? lane_wdata : '0;
                dmem_req_byte_enable <= is_store ? lane_be : '1;
            end else if (state == REQUEST && dmem_req_ready) begin
                dmem_req_valid <= 1'b0;
            end
            if (state == WAIT_RESPONSE && dmem_resp_valid)
                out_q.data_from_memory <= dmem_resp_rdata >> {out_q.alu_result[1:0], 3'b000};
        end
    end
endmodule
